// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer feeding the framebuffer pixel-write port.
// Writes are paced with WRITE_GAP idle cycles so the framebuffer's z-check/write sequence is never overrun.
module line_rasterizer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int WRITE_GAP = 3
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  input  logic [10:0] x1,
  input  logic [10:0] y1,
  input  logic [15:0] z_in,
  input  logic [15:0] color_in,
  output logic        busy,
  output logic        done,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [15:0] z,
  output logic [15:0] pixel_color,
  output logic        pixel_write
);

  localparam int WW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [WW-1:0] GAP_LOAD = WW'(WRITE_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PLOT, WAIT, STEP, DONE} state_t;
  state_t state;

  logic [10:0]        x0_r, y0_r, x1_r, y1_r;
  logic signed [12:0] dx, dy, err;
  logic               sx_neg, sy_neg;
  logic [WW-1:0]      wait_cnt;

  logic [10:0]        adx, ady, nx, ny;
  logic signed [13:0] e2, dx_ext, dy_ext;
  logic signed [12:0] err_nx;
  logic               step_x, step_y, at_end;

  always_comb begin
    adx    = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
    ady    = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
    e2     = {err, 1'b0};
    dx_ext = {dx[12], dx};
    dy_ext = {dy[12], dy};
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);
    nx     = x;
    ny     = y;
    err_nx = err;
    if (step_x) begin
      nx     = sx_neg ? (x - 11'd1) : (x + 11'd1);
      err_nx = err_nx + dy;
    end
    if (step_y) begin
      ny     = sy_neg ? (y - 11'd1) : (y + 11'd1);
      err_nx = err_nx + dx;
    end
    at_end = (x == x1_r) && (y == y1_r);
  end

  // pixel_write is set on the edge into PLOT so the strobe lines up with the PLOT cycle
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      pixel_color <= '0;
      pixel_write <= 1'b0;
      x0_r        <= '0;
      y0_r        <= '0;
      x1_r        <= '0;
      y1_r        <= '0;
      dx          <= '0;
      dy          <= '0;
      err         <= '0;
      sx_neg      <= 1'b0;
      sy_neg      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          pixel_write <= 1'b0;
          if (start) begin
            x0_r        <= x0;
            y0_r        <= y0;
            x1_r        <= x1;
            y1_r        <= y1;
            z           <= z_in;
            pixel_color <= color_in;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          dx          <= {2'b00, adx};
          dy          <= -{2'b00, ady};
          err         <= {2'b00, adx} - {2'b00, ady};
          sx_neg      <= !(x1_r > x0_r);
          sy_neg      <= !(y1_r > y0_r);
          x           <= x0_r;
          y           <= y0_r;
          pixel_write <= (x0_r < H_LIM) && (y0_r < V_LIM);
          state       <= PLOT;
        end
        PLOT: begin
          pixel_write <= 1'b0;
          if (pixel_write) begin
            wait_cnt <= GAP_LOAD;
            state    <= WAIT;
          end else if (at_end) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= STEP;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (at_end) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= STEP;
          end
        end
        STEP: begin
          x           <= nx;
          y           <= ny;
          err         <= err_nx;
          pixel_write <= (nx < H_LIM) && (ny < V_LIM);
          state       <= PLOT;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed lines plus random lines against a Bresenham reference model.
module tb_line_rasterizer;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [15:0] z_in = '0, color_in = '0;
  logic        busy, done, pixel_write;
  logic [10:0] x, y;
  logic [15:0] z, pixel_color;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int obs_x[$], obs_y[$], obs_z[$], obs_c[$], obs_t[$], done_t[$];
  int exp_x[$], exp_y[$], exp_t[$];
  int exp_done;

  line_rasterizer dut (
    .clk50(clk50), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .z_in(z_in), .color_in(color_in),
    .busy(busy), .done(done), .x(x), .y(y), .z(z),
    .pixel_color(pixel_color), .pixel_write(pixel_write)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (pixel_write) begin
      obs_x.push_back(int'(x));
      obs_y.push_back(int'(y));
      obs_z.push_back(int'(z));
      obs_c.push_back(int'(pixel_color));
      obs_t.push_back(cyc);
    end
    if (done) done_t.push_back(cyc);
  end

  task automatic clear_obs();
    obs_x.delete(); obs_y.delete(); obs_z.delete();
    obs_c.delete(); obs_t.delete(); done_t.delete();
  endtask

  // Textbook Bresenham walk; writes cost 5 cycles, clipped points 2, first point at cycle 2
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int cx, cy, ddx, ddy, sx, sy, e, e2, t;
    bit on;
    exp_x.delete(); exp_y.delete(); exp_t.delete();
    ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax1 > ax0) ? 1 : -1;
    sy = (ay1 > ay0) ? 1 : -1;
    e = ddx + ddy;
    cx = ax0; cy = ay0; t = 2;
    forever begin
      on = (cx < 640) && (cy < 480);
      if (on) begin
        exp_x.push_back(cx); exp_y.push_back(cy); exp_t.push_back(t);
      end
      if (cx == ax1 && cy == ay1) begin
        exp_done = on ? t + 4 : t + 1;
        break;
      end
      t = t + (on ? 5 : 2);
      e2 = 2 * e;
      if (e2 >= ddy) begin e = e + ddy; cx = cx + sx; end
      if (e2 <= ddx) begin e = e + ddx; cy = cy + sy; end
    end
  endtask

  task automatic run_line(input string name, input int ax0, input int ay0, input int ax1, input int ay1,
                          input int zz, input int cc, input bit poke);
    int t0, n;
    build_model(ax0, ay0, ax1, ay1);
    @(negedge clk50);
    clear_obs();
    x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
    z_in = 16'(zz); color_in = 16'(cc);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk50);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    else passed++;
    if (poke) begin
      @(negedge clk50);
      x0 = 11'd5; y0 = 11'd6; x1 = 11'd50; y1 = 11'd60;
      z_in = 16'hdead; color_in = 16'hbeef; start = 1'b1;
      @(negedge clk50);
      start = 1'b0;
    end
    for (int i = 0; i < 20000 && done_t.size() == 0; i++) @(negedge clk50);
    @(negedge clk50);
    total++;
    if (done_t.size() == 0) begin
      $display("FAIL %s done_timeout: got no done within bound want done", name);
      return;
    end
    passed++;
    total++;
    if (obs_x.size() != exp_x.size())
      $display("FAIL %s write_count: got %0d want %0d", name, obs_x.size(), exp_x.size());
    else passed++;
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_z[i] !== zz || obs_c[i] !== cc)
        $display("FAIL %s pixel[%0d]: got (%0d,%0d) z=%h c=%h want (%0d,%0d) z=%h c=%h", name, i,
                 obs_x[i], obs_y[i], obs_z[i], obs_c[i], exp_x[i], exp_y[i], zz, cc);
      else passed++;
      total++;
      if (obs_t[i] - t0 !== exp_t[i])
        $display("FAIL %s write_time[%0d]: got cycle %0d want %0d", name, i, obs_t[i] - t0, exp_t[i]);
      else passed++;
    end
    total++;
    if (done_t[0] - t0 !== exp_done)
      $display("FAIL %s done_time: got cycle %0d want %0d", name, done_t[0] - t0, exp_done);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s idle_after_done: got busy=%b done=%b want 0 0", name, busy, done);
    else passed++;
    repeat (8) @(negedge clk50);
    total++;
    if (done_t.size() != 1 || obs_x.size() != exp_x.size())
      $display("FAIL %s quiet_after_done: got dones=%0d writes=%0d want 1 %0d", name,
               done_t.size(), obs_x.size(), exp_x.size());
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk50);
    total++;
    if ({busy, done, pixel_write, x, y, z, pixel_color} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b pw=%b x=%0d y=%0d z=%h c=%h want all 0",
               busy, done, pixel_write, x, y, z, pixel_color);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_line("horizontal", 0, 0, 3, 0, 16'h1234, 16'hf00f, 1'b0);
    run_line("shallow", 0, 0, 4, 2, 16'h0042, 16'h07e0, 1'b0);
    run_line("reverse_diag", 10, 10, 7, 13, 16'h8000, 16'h001f, 1'b0);
    run_line("clip", 638, 5, 641, 5, 16'h5555, 16'haaaa, 1'b0);
    run_line("single_point", 100, 200, 100, 200, 16'h0001, 16'hffff, 1'b0);
    run_line("offscreen", 700, 500, 705, 490, 16'h0002, 16'h0003, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_line("start_while_busy", 20, 30, 26, 27, 16'h7777, 16'h3333, 1'b1);
  endtask

  task automatic test_reset_mid_line();
    @(negedge clk50);
    clear_obs();
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd20; y1 = 11'd0;
    z_in = 16'h0abc; color_in = 16'h0def; start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    for (int i = 0; i < 100 && obs_x.size() < 2; i++) @(negedge clk50);
    #2 reset = 1'b1;
    #1;
    total++;
    if (pixel_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_line_outputs: got pw=%b busy=%b done=%b want 0 0 0", pixel_write, busy, done);
    else passed++;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    repeat (12) @(negedge clk50);
    total++;
    if (obs_x.size() != 2 || done_t.size() != 0)
      $display("FAIL reset_mid_line_abort: got writes=%0d dones=%0d want 2 0", obs_x.size(), done_t.size());
    else passed++;
    run_line("after_reset", 3, 4, 6, 8, 16'h4321, 16'h1357, 1'b0);
  endtask

  task automatic test_random();
    int ax0, ay0, ax1, ay1;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        ax0 = $urandom_range(680, 600); ay0 = $urandom_range(520, 440);
      end else begin
        ax0 = $urandom_range(2000, 0); ay0 = $urandom_range(2000, 0);
      end
      ax1 = ax0 + $urandom_range(60, 0) - 30;
      ay1 = ay0 + $urandom_range(60, 0) - 30;
      if (ax1 < 0) ax1 = 0;
      if (ay1 < 0) ay1 = 0;
      run_line($sformatf("random%0d", k), ax0, ay0, ax1, ay1, int'($urandom_range(65535, 0)),
               int'($urandom_range(65535, 0)), k % 5 == 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_line();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
